matrix_mult_host: RTL and testbench

MATRIX_MULT_HOST -- requirements
Module: matrix_mult_host

---
 rtl/matrix_mult_host_if.sv | 30 +++
 rtl/matrix_mult_host.sv | 112 +++++++++++
 tb/tb_matrix_mult_host.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_host_if.sv
// Byte-stream, result-stream and multiplier-side signals of matrix_mult_host.
interface matrix_mult_host_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        timeout_err;
    logic [71:0] mm_A;
    logic [71:0] mm_B;
    logic        mm_reset;
    logic        mm_enable;
    logic [71:0] mm_C;
    logic        mm_done;

    modport master (
        input  in_data, in_valid, out_ready, mm_C, mm_done,
        output in_ready, out_data, out_valid, out_last, busy, timeout_err,
               mm_A, mm_B, mm_reset, mm_enable
    );

    modport slave (
        output in_data, in_valid, out_ready, mm_C, mm_done,
        input  in_ready, out_data, out_valid, out_last, busy, timeout_err,
               mm_A, mm_B, mm_reset, mm_enable
    );
endinterface

// File: rtl/matrix_mult_host.sv
// Loads two 3x3 byte matrices from a stream, runs an external multiplier, streams the 9 result bytes.
// Latency: one MRST cycle after byte 17, RUN until mm_done (abort after TIMEOUT cycles), then DRAIN.
// Backpressure: in_ready low outside IDLE/LOAD; DRAIN holds out_data/out_last while out_ready is low.
module matrix_mult_host #(
    parameter int TIMEOUT = 64
) (
    input  logic               Clock,
    input  logic               reset_n,
    matrix_mult_host_if.master bus
);
    localparam int RW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, MRST, RUN, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    byte_cnt;
    logic [3:0]    out_cnt;
    logic [RW-1:0] run_cnt;
    logic [71:0]   a_q;
    logic [71:0]   b_q;
    logic [71:0]   result_q;
    logic          timeout_q;
    logic          in_fire;
    logic          out_fire;
    logic          run_expired;
    logic [7:0]    out_byte;

    assign bus.in_ready = (state == IDLE) || (state == LOAD);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = (state == DRAIN) && bus.out_ready;
    assign run_expired  = (run_cnt == RW'(TIMEOUT - 1));

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire) state_nxt = LOAD;
            LOAD:    if (in_fire && byte_cnt == 5'd17) state_nxt = MRST;
            MRST:    state_nxt = RUN;
            RUN: begin
                if (bus.mm_done)      state_nxt = DRAIN;
                else if (run_expired) state_nxt = IDLE;
            end
            DRAIN:   if (out_fire && out_cnt == 4'd8) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt  <= '0;
            out_cnt   <= '0;
            run_cnt   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_fire) begin
                timeout_q <= 1'b0;
                byte_cnt  <= (byte_cnt == 5'd17) ? 5'd0 : byte_cnt + 5'd1;
                for (int i = 0; i < 9; i++) begin
                    if (byte_cnt == 5'(i))     a_q[i*8 +: 8] <= bus.in_data;
                    if (byte_cnt == 5'(i + 9)) b_q[i*8 +: 8] <= bus.in_data;
                end
            end

            // Counter sits at zero outside RUN so every RUN entry starts a fresh window.
            if (state != RUN) begin
                run_cnt <= '0;
            end else if (!bus.mm_done) begin
                run_cnt <= run_cnt + RW'(1);
            end

            if (state == RUN && bus.mm_done) begin
                result_q <= bus.mm_C;
                out_cnt  <= '0;
            end else if (state == RUN && run_expired) begin
                timeout_q <= 1'b1;
            end

            if (out_fire) begin
                out_cnt <= (out_cnt == 4'd8) ? 4'd0 : out_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        out_byte = 8'h00;
        for (int n = 0; n < 9; n++) begin
            if (out_cnt == 4'(n)) out_byte = result_q[n*8 +: 8];
        end
    end

    assign bus.out_data    = (state == DRAIN) ? out_byte : 8'h00;
    assign bus.out_valid   = (state == DRAIN);
    assign bus.out_last    = (state == DRAIN) && (out_cnt == 4'd8);
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_q;
    assign bus.mm_A        = a_q;
    assign bus.mm_B        = b_q;
    assign bus.mm_reset    = (state == MRST);
    assign bus.mm_enable   = (state == RUN);
endmodule

// File: tb/tb_matrix_mult_host.sv
// Randomized bench for matrix_mult_host: acts as stream source/sink and multiplier, checks every cycle against a protocol model.
module tb_matrix_mult_host;
    localparam int TO = 16;

    logic Clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 Clock = ~Clock;

    matrix_mult_host_if bus();

    matrix_mult_host #(.TIMEOUT(TO)) dut (
        .Clock   (Clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] matmul(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c;
        logic [7:0]  s;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 8'h00;
                for (int k = 0; k < 3; k++)
                    s = s + 8'(a[(i*3+k)*8 +: 8] * b[(k*3+j)*8 +: 8]);
                c[(i*3+j)*8 +: 8] = s;
            end
        end
        return c;
    endfunction

    // Multiplier stand-in: result after 'lat' enabled cycles; junk mm_done/mm_C whenever not enabled.
    logic stub_dead = 1'b0;
    int   lat       = 0;
    int   lat_cnt   = 0;
    always @(posedge Clock) begin
        #1;
        if (!bus.mm_enable) begin
            lat_cnt     = 0;
            bus.mm_done = ($urandom_range(0, 3) == 0);
            bus.mm_C    = {8'($urandom), $urandom, $urandom};
        end else begin
            bus.mm_done = !stub_dead && (lat_cnt >= lat);
            bus.mm_C    = matmul(bus.mm_A, bus.mm_B);
            lat_cnt++;
        end
    end

    // Sink: 0 = always ready, 1 = random, 2 = repeating 1-0-0-1.
    int rdy_mode = 0;
    int rdy_ph   = 0;
    always @(posedge Clock) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: begin
                bus.out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
                rdy_ph++;
            end
        endcase
    end

    // Protocol model, driven only by bench-side signals. ph: 0 idle, 1 load, 2 mrst, 3 run, 4 drain.
    int          ph = 0, k = 0, rc = 0, n = 0;
    logic        err = 1'b0;
    logic [71:0] fa = '0, fb = '0, exp_res = '0;
    always @(posedge Clock) begin
        if (!reset_n) begin
            ph = 0; k = 0; rc = 0; n = 0; err = 1'b0;
            fa = '0; fb = '0; exp_res = '0;
        end else begin
            case (ph)
                0, 1: if (bus.in_valid) begin
                    err = 1'b0;
                    if (k < 9) fa[k*8 +: 8] = bus.in_data;
                    else       fb[(k-9)*8 +: 8] = bus.in_data;
                    if (k == 17) begin k = 0; ph = 2; end
                    else begin k++; ph = 1; end
                end
                2: begin ph = 3; rc = 0; end
                3: if (bus.mm_done) begin
                    exp_res = matmul(fa, fb);
                    n = 0;
                    ph = 4;
                end else begin
                    rc++;
                    if (rc == TO) begin err = 1'b1; ph = 0; end
                end
                4: if (bus.out_ready) begin
                    if (n == 8) ph = 0;
                    else n++;
                end
                default: ph = 0;
            endcase
        end
    end

    logic [7:0] got[$];
    logic       got_last[$];
    int         en_cycles = 0;
    always @(negedge Clock) begin
        if (!reset_n) begin
            chk("rst_busy",        72'(bus.busy),        72'(0));
            chk("rst_out_valid",   72'(bus.out_valid),   72'(0));
            chk("rst_out_last",    72'(bus.out_last),    72'(0));
            chk("rst_out_data",    72'(bus.out_data),    72'(0));
            chk("rst_timeout_err", 72'(bus.timeout_err), 72'(0));
            chk("rst_mm_reset",    72'(bus.mm_reset),    72'(0));
            chk("rst_mm_enable",   72'(bus.mm_enable),   72'(0));
            chk("rst_mm_A",        bus.mm_A,             72'(0));
            chk("rst_mm_B",        bus.mm_B,             72'(0));
        end else begin
            chk("busy",        72'(bus.busy),        72'(ph != 0));
            chk("in_ready",    72'(bus.in_ready),    72'(ph <= 1));
            chk("mm_reset",    72'(bus.mm_reset),    72'(ph == 2));
            chk("mm_enable",   72'(bus.mm_enable),   72'(ph == 3));
            chk("out_valid",   72'(bus.out_valid),   72'(ph == 4));
            chk("timeout_err", 72'(bus.timeout_err), 72'(err));
            if (ph == 4) begin
                chk("out_data", 72'(bus.out_data), 72'(exp_res[n*8 +: 8]));
                chk("out_last", 72'(bus.out_last), 72'(n == 8));
            end else begin
                chk("out_last_quiet", 72'(bus.out_last), 72'(0));
            end
            if (ph == 2) begin
                chk("mm_A_loaded", bus.mm_A, fa);
                chk("mm_B_loaded", bus.mm_B, fb);
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
            end
            if (bus.mm_enable) en_cycles++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] fr [18], input int gaps, input int first);
        for (int i = first; i < 18; i++) begin
            int g;
            g = (gaps > 0) ? int'($urandom_range(0, gaps)) : 0;
            bus.in_valid = 1'b0;
            repeat (g) tick();
            bus.in_valid = 1'b1;
            bus.in_data  = fr[i];
            tick();
        end
        // Keep offering junk while the block is busy; it must not be taken.
        bus.in_data = 8'hA5;
        repeat (3) tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (ph != 0 && c < 500) begin
            tick();
            c++;
        end
        chk({name, "_finished"}, 72'(c < 500), 72'(1));
    endtask

    logic [7:0] fr [18];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        bus.mm_done   = 1'b0;
        bus.mm_C      = '0;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("in_ready_after_reset", 72'(bus.in_ready), 72'(1));

        // Identity times 1..9.
        for (int i = 0; i < 18; i++)
            fr[i] = (i < 9) ? ((i % 4 == 0) ? 8'd1 : 8'd0) : 8'(i - 8);
        lat = 3;
        got.delete(); got_last.delete();
        send_frame(fr, 0, 0);
        wait_idle("identity");
        chk("identity_count", 72'(got.size()), 72'(9));
        if (got.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("identity_byte", 72'(got[i]), 72'(i + 1));
                chk("identity_last", 72'(got_last[i]), 72'(i == 8));
            end
        end
        chk("identity_busy_low", 72'(bus.busy), 72'(0));

        // All 0x10: every sum is 3*256, wraps to 0; sink stalls 1-0-0-1.
        for (int i = 0; i < 18; i++) fr[i] = 8'h10;
        lat = 0;
        rdy_mode = 2; rdy_ph = 0;
        got.delete(); got_last.delete();
        send_frame(fr, 0, 0);
        wait_idle("wrap");
        rdy_mode = 0;
        chk("wrap_handshakes", 72'(got.size()), 72'(9));
        if (got.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("wrap_byte", 72'(got[i]), 72'(0));
                chk("wrap_last", 72'(got_last[i]), 72'(i == 8));
            end
        end

        // Timeout: multiplier never answers.
        for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
        stub_dead = 1'b1;
        en_cycles = 0;
        got.delete(); got_last.delete();
        send_frame(fr, 2, 0);
        wait_idle("timeout");
        chk("timeout_enable_cycles", 72'(en_cycles), 72'(TO));
        chk("timeout_flag",          72'(bus.timeout_err), 72'(1));
        chk("timeout_in_ready",      72'(bus.in_ready), 72'(1));
        chk("timeout_no_output",     72'(got.size()), 72'(0));
        stub_dead = 1'b0;
        repeat (2) tick();
        chk("timeout_sticky", 72'(bus.timeout_err), 72'(1));
        for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = fr[0];
        tick();
        chk("timeout_cleared_by_byte", 72'(bus.timeout_err), 72'(0));
        lat = 5;
        send_frame(fr, 1, 1);
        wait_idle("after_timeout");

        // Reset after five bytes, then a fresh frame.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
        lat = 2;
        got.delete(); got_last.delete();
        send_frame(fr, 0, 0);
        wait_idle("post_reset");
        chk("post_reset_count", 72'(got.size()), 72'(9));

        // Random frames, random gaps, random latency, random sink stalls.
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
            lat = $urandom_range(0, 10);
            got.delete(); got_last.delete();
            send_frame(fr, 3, 0);
            wait_idle("random");
            chk("random_count", 72'(got.size()), 72'(9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
